mdio_slave: RTL and testbench
=============================

Name: mdio_slave

Overview:
- Clause-22 MDIO responder (PHY-side target) for the management bus.
- Decodes frames from an MDIO master; on writes, emits a one-cycle register-write strobe; on reads, fetches 16-bit data over a local read port and drives it back on MDIO.
- Used for PHY-register emulation in loopback/sim builds and as a managed-device endpoint on the board management bus.

Parameters:
- PHY_ADDR, 5'h01, PHY address this block answers to.
- PRE_LEN, 32, minimum consecutive '1' bits required before ST (1..32).
- BCAST_EN, 0, when 1, PHYAD 5'h00 is also accepted, for writes only.

Ports:
- clk_i  in  1  system clock; must be ≥ 4× MDC frequency.
- rst  in  1  synchronous, active-high reset.
- mdc_i  in  1  MDC from master; asynchronous to clk_i.
- mdio_i  in  1  MDIO pad input; asynchronous.
- mdio_o  out  1  MDIO output value.
- mdio_t  out  1  tristate enable; 1 = released (high-Z).
- rd_strobe  out  1  one-cycle read request.
- rd_addr  out  5  register address for read.
- rd_data  in  16  read data; sampled the clk_i cycle after rd_strobe.
- wr_strobe  out  1  one-cycle write pulse.
- wr_addr  out  5  write register address.
- wr_data  out  16  write data.
- busy  out  1  high from ST detection until the frame ends or aborts.
- frame_err  out  1  one-cycle pulse on an aborted or malformed frame.

Behaviour:
- Reset values: mdio_o=1, mdio_t=1, rd_strobe=0, wr_strobe=0, rd_addr=0, wr_addr=0, wr_data=0, busy=0, frame_err=0. State=PREAMBLE, preamble count=0.
- Reset mid-frame releases MDIO (mdio_t=1) on the next clk_i edge; a partial write never strobes.
- Input conditioning: mdc_i and mdio_i pass through 2-flop synchronizers. A rising MDC edge is a one-cycle pulse (sync=1, previous=0). All bit sampling and all mdio_o/mdio_t updates occur only on that pulse cycle.
- Below, "edge" means a detected rising MDC edge.
- PREAMBLE:
  - Bit=1: count++, saturating at PRE_LEN.
  - Bit=0 with count ≥ PRE_LEN: go to ST2, busy=1.
  - Bit=0 with count < PRE_LEN: count=0.
- ST2: bit=1 → OP. Bit=0 → frame_err, PREAMBLE with count=0.
- OP: two bits. 2'b01 = write, 2'b10 = read. 2'b00 or 2'b11 → frame_err, PREAMBLE with count=0.
- ADDR: 10 bits, PHYAD then REGAD, MSB first. At the edge capturing REGAD[0] (call it edge k):
  - PHYAD==PHY_ADDR, or (BCAST_EN && PHYAD==0 && write): accept the frame.
  - Otherwise: IGNORE. Never drive MDIO; return to PREAMBLE with count=0 at edge k+18. No frame_err.
  - Accepted read: rd_strobe=1 and rd_addr=REGAD in the cycle after edge k. The following cycle, rd_data is latched into the 16-bit shift register.
- Read response timing:
  - Edge k+1: mdio_t=0, mdio_o=0 (TA second bit).
  - Edges k+2..k+17: mdio_o = data[15]..data[0].
  - Edge k+18: mdio_t=1, mdio_o=1, busy=0, PREAMBLE with count=0.
  - During the first TA bit (k to k+1), MDIO stays released.
- Write:
  - Edges k+1, k+2: TA bits sampled. A value other than 2'b10 pulses frame_err; the write still proceeds.
  - Edges k+3..k+18: data MSB first.
  - One cycle after edge k+18: wr_strobe=1 with wr_addr/wr_data valid. wr_addr/wr_data hold until the next write.
  - busy=0, PREAMBLE with count=0.
- The preamble count restarts at 0 after every frame. Back-to-back frames need a full PRE_LEN preamble.
- MDC stopping mid-frame: state holds indefinitely; no timeout.
- rd_strobe and wr_strobe are never both high.

Decomposition:
- Package mdio_pkg holds:
  - ST pattern 2'b01, OP_WRITE=2'b01, OP_READ=2'b10, TA_WRITE=2'b10;
  - field widths PHYAD_W=5, REGAD_W=5, DATA_W=16;
  - state enum (PREAMBLE, ST2, OP, ADDR, TA_DATA_RD, TA_DATA_WR, IGNORE).
- One sub-module, mdio_sync_edge: 2-flop synchronizers for MDC/MDIO plus rising-edge pulse generation.

Test Plan:
- Write frame: 32×'1', 01, 01, PHYAD=PHY_ADDR, REGAD=5'h09, TA=10, data 16'h0000 → one wr_strobe pulse with wr_addr=5'h09, wr_data=16'h0000; mdio_t=1 throughout.
- Read frame with REGAD=5'h02 and rd_data=16'h001C → rd_strobe with rd_addr=5'h02; mdio_t=0 from edge k+1 to k+18; master samples 0 then 16'h001C MSB first; mdio_t=1 after.
- PHYAD mismatch on a read (PHYAD=5'h1F) → no rd_strobe, mdio_t stays 1, no frame_err; the next valid frame decodes correctly.
- Short preamble (31 ones) then 01 → frame ignored, no strobes. With 32 ones → accepted.
- Invalid opcode 2'b11 → frame_err pulse, busy drops, no strobes. Back-to-back valid write to REGAD=0 with data 16'h1340 → wr_data=16'h1340.
- Assert rst during a read data phase at bit 8 → mdio_t=1 next cycle, all outputs at reset values; the subsequent full read completes correctly.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared constants and state encoding for the Clause-22 MDIO responder.
package mdio_pkg;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  localparam logic [1:0] ST_PAT   = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  typedef enum logic [2:0] {
    PREAMBLE,
    ST2,
    OP,
    ADDR,
    TA_DATA_RD,
    TA_DATA_WR,
    IGNORE
  } mdio_state_e;
endpackage

// File: rtl/mdio_sync_edge.sv
// Brings MDC/MDIO into clk_i and turns rising MDC into a one-cycle pulse.
module mdio_sync_edge (
  input  logic clk_i,
  input  logic rst,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise,
  output logic mdio_s
);
  logic [1:0] mdc_sync;
  logic [1:0] mdio_sync;
  logic       mdc_prev;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      mdc_sync  <= 2'b00;
      mdio_sync <= 2'b00;
      mdc_prev  <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[0], mdc_i};
      mdio_sync <= {mdio_sync[0], mdio_i};
      mdc_prev  <= mdc_sync[1];
    end
  end

  assign mdc_rise = mdc_sync[1] & ~mdc_prev;
  assign mdio_s   = mdio_sync[1];
endmodule

// File: rtl/mdio_slave.sv
// Clause-22 MDIO target: decodes frames, strobes register writes and
// serves register reads back onto MDIO.
module mdio_slave
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'h01,
  parameter int                 PRE_LEN  = 32,
  parameter bit                 BCAST_EN = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst,
  input  logic               mdc_i,
  input  logic               mdio_i,
  output logic               mdio_o,
  output logic               mdio_t,
  output logic               rd_strobe,
  output logic [REGAD_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               wr_strobe,
  output logic [REGAD_W-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               frame_err
);
  localparam logic [5:0] PRE_MAX = 6'(PRE_LEN);

  logic mdc_rise, mdio_s;

  mdio_sync_edge u_sync (
    .clk_i    (clk_i),
    .rst      (rst),
    .mdc_i    (mdc_i),
    .mdio_i   (mdio_i),
    .mdc_rise (mdc_rise),
    .mdio_s   (mdio_s)
  );

  mdio_state_e         state_q, state_d;
  logic [5:0]          pre_cnt_q, pre_cnt_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [1:0]          op_q, op_d;
  logic [8:0]          addr_q, addr_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                ta_q, ta_d;
  logic                rd_latch_q;
  logic                mdio_o_d, mdio_t_d, busy_d, frame_err_d;
  logic                rd_strobe_d, wr_strobe_d;
  logic [REGAD_W-1:0]  rd_addr_d, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;

  // Address shifted with the bit currently on the wire; complete at REGAD[0].
  logic [9:0]         addr_shift;
  logic [PHYAD_W-1:0] phyad_in;
  logic [REGAD_W-1:0] regad_in;
  logic               is_write, accept;

  assign addr_shift = {addr_q, mdio_s};
  assign phyad_in   = addr_shift[9:5];
  assign regad_in   = addr_shift[4:0];
  assign is_write   = (op_q == OP_WRITE);
  assign accept     = (phyad_in == PHY_ADDR) ||
                      (BCAST_EN && (phyad_in == '0) && is_write);

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    shreg_d     = shreg_q;
    ta_d        = ta_q;
    mdio_o_d    = mdio_o;
    mdio_t_d    = mdio_t;
    busy_d      = busy;
    frame_err_d = 1'b0;
    rd_strobe_d = 1'b0;
    wr_strobe_d = 1'b0;
    rd_addr_d   = rd_addr;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;

    if (rd_latch_q) shreg_d = rd_data;

    if (mdc_rise) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      unique case (state_q)
        PREAMBLE: begin
          bit_cnt_d = '0;
          if (mdio_s) begin
            if (pre_cnt_q < PRE_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
          end else if (pre_cnt_q >= PRE_MAX) begin
            state_d   = ST2;
            busy_d    = 1'b1;
            pre_cnt_d = '0;
          end else begin
            pre_cnt_d = '0;
          end
        end
        ST2: begin
          bit_cnt_d = '0;
          if ({1'b0, mdio_s} == ST_PAT) begin
            state_d = OP;
          end else begin
            state_d     = PREAMBLE;
            busy_d      = 1'b0;
            frame_err_d = 1'b1;
          end
        end
        OP: begin
          op_d = {op_q[0], mdio_s};
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d = '0;
            if (op_d == OP_WRITE || op_d == OP_READ) begin
              state_d = ADDR;
            end else begin
              state_d     = PREAMBLE;
              busy_d      = 1'b0;
              frame_err_d = 1'b1;
            end
          end
        end
        ADDR: begin
          addr_d = addr_shift[8:0];
          if (bit_cnt_q == 5'd9) begin
            bit_cnt_d = '0;
            if (!accept) begin
              state_d = IGNORE;
            end else if (is_write) begin
              state_d = TA_DATA_WR;
            end else begin
              state_d     = TA_DATA_RD;
              rd_strobe_d = 1'b1;
              rd_addr_d   = regad_in;
            end
          end
        end
        TA_DATA_RD: begin
          if (bit_cnt_q == 5'd0) begin
            mdio_t_d = 1'b0;
            mdio_o_d = 1'b0;
          end else if (bit_cnt_q <= 5'd16) begin
            mdio_o_d = shreg_q[DATA_W-1];
            shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
          end else begin
            mdio_t_d  = 1'b1;
            mdio_o_d  = 1'b1;
            busy_d    = 1'b0;
            state_d   = PREAMBLE;
            bit_cnt_d = '0;
          end
        end
        TA_DATA_WR: begin
          // A bad turnaround is flagged but the write is still carried out.
          if (bit_cnt_q == 5'd0) begin
            ta_d = mdio_s;
          end else if (bit_cnt_q == 5'd1) begin
            if ({ta_q, mdio_s} != TA_WRITE) frame_err_d = 1'b1;
          end else begin
            shreg_d = {shreg_q[DATA_W-2:0], mdio_s};
            if (bit_cnt_q == 5'd17) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q[4:0];
              wr_data_d   = shreg_d;
              busy_d      = 1'b0;
              state_d     = PREAMBLE;
              bit_cnt_d   = '0;
            end
          end
        end
        IGNORE: begin
          if (bit_cnt_q == 5'd17) begin
            busy_d    = 1'b0;
            state_d   = PREAMBLE;
            bit_cnt_d = '0;
          end
        end
        default: begin
          state_d   = PREAMBLE;
          pre_cnt_d = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b0;
          mdio_t_d  = 1'b1;
          mdio_o_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= PREAMBLE;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      shreg_q    <= '0;
      ta_q       <= 1'b0;
      rd_latch_q <= 1'b0;
      mdio_o     <= 1'b1;
      mdio_t     <= 1'b1;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      rd_strobe  <= 1'b0;
      wr_strobe  <= 1'b0;
      rd_addr    <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      shreg_q    <= shreg_d;
      ta_q       <= ta_d;
      rd_latch_q <= rd_strobe;
      mdio_o     <= mdio_o_d;
      mdio_t     <= mdio_t_d;
      busy       <= busy_d;
      frame_err  <= frame_err_d;
      rd_strobe  <= rd_strobe_d;
      wr_strobe  <= wr_strobe_d;
      rd_addr    <= rd_addr_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_mdio_slave.sv
// Self-checking bench for mdio_slave: table-driven frames, randomized frames
// against a frame-level model, and a reset-during-read sequence.
module tb_mdio_slave;
  localparam int HALF = 4;
  localparam logic [4:0] PHY = 5'h01;
  localparam int PRE_MIN = 32;

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        mdc_i = 1'b0;
  logic        drv = 1'b1;
  logic [15:0] rd_data = '0;
  logic        mdio_o, mdio_t, rd_strobe, wr_strobe, busy, frame_err;
  logic [4:0]  rd_addr, wr_addr;
  logic [15:0] wr_data;
  logic        mdio_line;

  // Open-drain style bus: master value (1 when released) unless the DUT drives.
  assign mdio_line = mdio_t ? drv : mdio_o;

  always #5 clk_i = ~clk_i;

  mdio_slave #(.PHY_ADDR(PHY), .PRE_LEN(32), .BCAST_EN(1'b0)) dut (
    .clk_i(clk_i), .rst(rst), .mdc_i(mdc_i), .mdio_i(mdio_line),
    .mdio_o(mdio_o), .mdio_t(mdio_t), .rd_strobe(rd_strobe), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail = 0;

  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [4:0]  mon_wr_addr = '0, mon_rd_addr = '0;
  logic [15:0] mon_wr_data = '0;

  always @(negedge clk_i) begin
    if (wr_strobe) begin
      wr_cnt++;
      mon_wr_addr = wr_addr;
      mon_wr_data = wr_data;
    end
    if (rd_strobe) begin
      rd_cnt++;
      mon_rd_addr = rd_addr;
    end
    if (frame_err) err_cnt++;
    if (wr_strobe && rd_strobe) both_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         pre;
    logic [1:0] op;
    logic [4:0] phy;
    logic [4:0] rg;
    logic [1:0] ta;
    logic [15:0] data;
    logic [15:0] rdd;
    int         exp_wr;
    int         exp_rd;
    int         exp_err;
  } vec_t;

  // Model state carried between frames.
  int          idle_ones = 0;
  logic [4:0]  m_wr_addr = '0;
  logic [15:0] m_wr_data = '0;

  bit bits_q[$];
  bit exp_t_q[$];
  bit exp_l_q[$];

  task automatic build_frame(input vec_t v, input bit acc_rd);
    bit drive;
    bits_q.delete(); exp_t_q.delete(); exp_l_q.delete();
    for (int i = 0; i < v.pre; i++) bits_q.push_back(1'b1);
    bits_q.push_back(1'b0); bits_q.push_back(1'b1);
    bits_q.push_back(v.op[1]); bits_q.push_back(v.op[0]);
    for (int i = 4; i >= 0; i--) bits_q.push_back(v.phy[i]);
    for (int i = 4; i >= 0; i--) bits_q.push_back(v.rg[i]);
    if (v.op == 2'b10) begin
      for (int i = 0; i < 18; i++) bits_q.push_back(1'b1);
    end else begin
      bits_q.push_back(v.ta[1]); bits_q.push_back(v.ta[0]);
      for (int i = 15; i >= 0; i--) bits_q.push_back(v.data[i]);
    end
    // Slot pre+14 is TA1; the target drives from TA2 through D0.
    for (int j = 0; j < bits_q.size(); j++) begin
      drive = acc_rd && (j >= v.pre + 15);
      exp_t_q.push_back(!drive);
      if (!drive) exp_l_q.push_back(bits_q[j]);
      else if (j == v.pre + 15) exp_l_q.push_back(1'b0);
      else exp_l_q.push_back(v.rdd[15 - (j - v.pre - 16)]);
    end
  endtask

  task automatic drive_bit(input bit b, output bit t_s, output bit l_s);
    drv = b;
    mdc_i = 1'b0;
    repeat (HALF) @(negedge clk_i);
    t_s = mdio_t;
    l_s = mdio_line;
    mdc_i = 1'b1;
    repeat (HALF) @(negedge clk_i);
  endtask

  task automatic run_frame(input vec_t v, input bit use_tab, input string tag);
    bit started, valid_op, acc, t_s, l_s, busy_obs;
    int e_wr, e_rd, e_err, w0, r0, f0, b0, bad_t, bad_l, tr, after_op;
    started  = (idle_ones + v.pre) >= PRE_MIN;
    valid_op = (v.op == 2'b01) || (v.op == 2'b10);
    acc      = started && valid_op && (v.phy == PHY);
    e_wr  = (acc && v.op == 2'b01) ? 1 : 0;
    e_rd  = (acc && v.op == 2'b10) ? 1 : 0;
    e_err = ((started && !valid_op) ? 1 : 0) + ((e_wr == 1 && v.ta != 2'b10) ? 1 : 0);
    if (use_tab) begin
      e_wr = v.exp_wr; e_rd = v.exp_rd; e_err = v.exp_err;
    end
    build_frame(v, e_rd == 1);
    rd_data = v.rdd;
    w0 = wr_cnt; r0 = rd_cnt; f0 = err_cnt; b0 = both_cnt;
    bad_t = -1; bad_l = -1; busy_obs = 1'b0;
    for (int j = 0; j < bits_q.size(); j++) begin
      drive_bit(bits_q[j], t_s, l_s);
      if (t_s !== exp_t_q[j] && bad_t < 0) bad_t = j;
      if (l_s !== exp_l_q[j] && bad_l < 0) bad_l = j;
      if (j == v.pre + 13) busy_obs = busy;
    end
    mdc_i = 1'b0;
    drv = 1'b1;
    repeat (4) @(negedge clk_i);

    check({tag, " wr_strobes"}, wr_cnt - w0, e_wr);
    check({tag, " rd_strobes"}, rd_cnt - r0, e_rd);
    check({tag, " frame_errs"}, err_cnt - f0, e_err);
    check({tag, " both_strobes"}, both_cnt - b0, 0);
    check({tag, " mdio_t slot"}, bad_t, -1);
    check({tag, " mdio line slot"}, bad_l, -1);
    check({tag, " busy mid"}, busy_obs, (started && valid_op) ? 1 : 0);
    check({tag, " busy end"}, busy, 0);
    check({tag, " mdio_t end"}, mdio_t, 1);
    if (e_wr == 1) begin
      m_wr_addr = v.rg;
      m_wr_data = v.data;
      check({tag, " strobe wr_addr"}, mon_wr_addr, v.rg);
      check({tag, " strobe wr_data"}, mon_wr_data, v.data);
    end
    if (e_rd == 1) check({tag, " rd_addr"}, mon_rd_addr, v.rg);
    check({tag, " wr_addr hold"}, wr_addr, m_wr_addr);
    check({tag, " wr_data hold"}, wr_data, m_wr_data);

    // Ones the target sees while idle carry into the next preamble.
    tr = 0;
    for (int j = bits_q.size() - 1; j >= 0 && bits_q[j]; j--) tr++;
    after_op = bits_q.size() - (v.pre + 4);
    if (!started) idle_ones = tr;
    else if (!valid_op) idle_ones = (tr < after_op) ? tr : after_op;
    else idle_ones = 0;
  endtask

  task automatic reset_check(input string tag);
    check({tag, " mdio_o"}, mdio_o, 1);
    check({tag, " mdio_t"}, mdio_t, 1);
    check({tag, " rd_strobe"}, rd_strobe, 0);
    check({tag, " wr_strobe"}, wr_strobe, 0);
    check({tag, " rd_addr"}, rd_addr, 0);
    check({tag, " wr_addr"}, wr_addr, 0);
    check({tag, " wr_data"}, wr_data, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " frame_err"}, frame_err, 0);
  endtask

  vec_t tab[12];
  vec_t v;

  initial begin
    tab[0]  = '{32, 2'b01, 5'h01, 5'h09, 2'b10, 16'h0000, 16'h0000, 1, 0, 0};
    tab[1]  = '{32, 2'b10, 5'h01, 5'h02, 2'b00, 16'h0000, 16'h001C, 0, 1, 0};
    tab[2]  = '{32, 2'b10, 5'h1F, 5'h02, 2'b00, 16'h0000, 16'hBEEF, 0, 0, 0};
    tab[3]  = '{32, 2'b01, 5'h01, 5'h07, 2'b10, 16'h5555, 16'h0000, 1, 0, 0};
    tab[4]  = '{31, 2'b01, 5'h01, 5'h06, 2'b10, 16'h0000, 16'h0000, 0, 0, 0};
    tab[5]  = '{32, 2'b01, 5'h01, 5'h06, 2'b10, 16'hA5A5, 16'h0000, 1, 0, 0};
    tab[6]  = '{32, 2'b11, 5'h01, 5'h03, 2'b10, 16'h0000, 16'h0000, 0, 0, 1};
    tab[7]  = '{32, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1340, 16'h0000, 1, 0, 0};
    tab[8]  = '{32, 2'b01, 5'h00, 5'h04, 2'b10, 16'hABCD, 16'h0000, 0, 0, 0};
    tab[9]  = '{32, 2'b01, 5'h01, 5'h0A, 2'b11, 16'hF00F, 16'h0000, 1, 0, 1};
    tab[10] = '{32, 2'b10, 5'h01, 5'h1F, 2'b00, 16'h0000, 16'hFFFF, 0, 1, 0};
    tab[11] = '{32, 2'b00, 5'h01, 5'h01, 2'b10, 16'h0000, 16'h0000, 0, 0, 1};

    repeat (5) @(negedge clk_i);
    rst = 1'b0;
    @(negedge clk_i);
    reset_check("reset");

    for (int i = 0; i < 12; i++) run_frame(tab[i], 1'b1, $sformatf("tab%0d", i));

    // Reset while the target is shifting read data (after D15..D8).
    v = '{32, 2'b10, 5'h01, 5'h05, 2'b00, 16'h0000, 16'hA5C3, 0, 1, 0};
    build_frame(v, 1'b1);
    rd_data = v.rdd;
    begin
      bit t_s, l_s;
      int bad_l;
      bad_l = -1;
      for (int j = 0; j <= v.pre + 23; j++) begin
        drive_bit(bits_q[j], t_s, l_s);
        if (l_s !== exp_l_q[j] && bad_l < 0) bad_l = j;
      end
      check("midrst line before reset", bad_l, -1);
      check("midrst driving before reset", mdio_t, 0);
    end
    rst = 1'b1;
    mdc_i = 1'b0;
    drv = 1'b1;
    @(negedge clk_i);
    reset_check("midrst");
    rst = 1'b0;
    idle_ones = 0;
    m_wr_addr = '0;
    m_wr_data = '0;
    repeat (3) @(negedge clk_i);
    run_frame(v, 1'b1, "post_rst_read");

    for (int i = 0; i < 40; i++) begin
      int r;
      v.pre = $urandom_range(34, 29);
      r = $urandom_range(7, 0);
      v.op = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r == 6) ? 2'b00 : 2'b11;
      r = $urandom_range(5, 0);
      v.phy = (r < 3) ? PHY : (r == 3) ? 5'h00 : (r == 4) ? 5'h1F : 5'($urandom);
      v.rg = 5'($urandom);
      v.ta = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b10;
      v.data = 16'($urandom);
      v.rdd = 16'($urandom);
      v.exp_wr = 0; v.exp_rd = 0; v.exp_err = 0;
      run_frame(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
